// File: rtl/cfg_chain_pkg.sv
// Shared types and CRC helper for the configuration chain transmitter.
package cfg_chain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_FINISH   = 3'd5
  } cfg_state_e;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  // One bit of an MSB-first CRC-8 over the serial chain stream.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_clk_div.sv
// Phase-tick generator: one-cycle tick every CLK_DIV cycles, restartable.
module cfg_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cfg_chain_shifter.sv
// Config chain transmitter: serialises loader words MSB-first, then strobes the chain latch.
// Optional trailing CRC-8 word check enabled by defining CFG_CHAIN_CRC_EN.
module cfg_chain_shifter
  import cfg_chain_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 256,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_cfg_clk,
  output logic              o_cfg_data,
  output logic              o_cfg_latch,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned REM_W = $clog2(WORD_W + 1);
  // The MSB goes straight to o_cfg_data, so only the lower bits are held.
  localparam int unsigned SHR_W = WORD_W - 1;

  cfg_state_e        r_state, w_state_nxt;
  logic [SHR_W-1:0]  r_shreg, w_shreg_nxt;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [REM_W-1:0]  r_word_rem, w_word_rem_nxt;
  logic              r_lat_ph, w_lat_ph_nxt;
  logic              r_cfg_clk, w_cfg_clk_nxt;
  logic              r_cfg_data, w_cfg_data_nxt;
  logic              r_cfg_latch, w_cfg_latch_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;

  logic              w_tick;
  logic              w_restart;
  logic              w_xfer;
  logic              w_last_bit;
  logic [31:0]       w_left;
  logic [REM_W-1:0]  w_take;
  logic              w_crc_ph;
  logic              w_crc_ok;

  cfg_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_restart),
    .o_tick_c  (w_tick)
  );

  assign o_word_ready = (r_state == ST_FETCH);
  assign w_xfer       = o_word_ready && i_word_valid;
  assign w_restart    = (w_state_nxt != r_state);
  assign w_last_bit   = (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));
  // Bits of the next word that still fit in the chain; the rest are dropped.
  assign w_left       = 32'(CHAIN_LEN) - 32'(r_bit_cnt);
  assign w_take       = (w_left < 32'(WORD_W)) ? REM_W'(w_left) : REM_W'(WORD_W);

`ifdef CFG_CHAIN_CRC_EN
  localparam bit CRC_EN = 1'b1;

  logic [7:0] r_crc;
  logic       r_crc_ph;

  // Running CRC over every bit clocked into the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc    <= CRC_INIT;
      r_crc_ph <= 1'b0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_crc    <= CRC_INIT;
      r_crc_ph <= 1'b0;
    end else if ((r_state == ST_SHIFT_HI) && w_tick) begin
      r_crc <= crc8_step(r_crc, r_cfg_data);
      if (w_last_bit) r_crc_ph <= 1'b1;
    end
  end

  assign w_crc_ph = r_crc_ph;
  assign w_crc_ok = (i_word_data[7:0] == r_crc);
`else
  localparam bit CRC_EN = 1'b0;

  assign w_crc_ph = 1'b0;
  assign w_crc_ok = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_word_rem_nxt  = r_word_rem;
    w_lat_ph_nxt    = r_lat_ph;
    w_cfg_clk_nxt   = r_cfg_clk;
    w_cfg_data_nxt  = r_cfg_data;
    w_cfg_latch_nxt = r_cfg_latch;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt   = ST_FETCH;
          w_busy_nxt    = 1'b1;
          w_err_nxt     = 1'b0;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_FETCH: begin
        w_cfg_clk_nxt = 1'b0;
        if (w_xfer) begin
          if (w_crc_ph) begin
            if (w_crc_ok) begin
              w_state_nxt     = ST_LATCH;
              w_cfg_latch_nxt = 1'b1;
              w_lat_ph_nxt    = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
              w_err_nxt   = 1'b1;
            end
          end else begin
            w_state_nxt    = ST_SHIFT_LO;
            w_shreg_nxt    = i_word_data[SHR_W-1:0];
            w_cfg_data_nxt = i_word_data[WORD_W-1];
            w_word_rem_nxt = w_take;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (w_tick) begin
          w_state_nxt   = ST_SHIFT_HI;
          w_cfg_clk_nxt = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (w_tick) begin
          w_cfg_clk_nxt  = 1'b0;
          w_shreg_nxt    = r_shreg << 1;
          w_bit_cnt_nxt  = r_bit_cnt + BIT_W'(1);
          w_word_rem_nxt = r_word_rem - REM_W'(1);
          if (w_last_bit) begin
            if (CRC_EN) begin
              w_state_nxt = ST_FETCH;
            end else begin
              w_state_nxt     = ST_LATCH;
              w_cfg_latch_nxt = 1'b1;
              w_lat_ph_nxt    = 1'b0;
            end
          end else if (r_word_rem != REM_W'(1)) begin
            w_state_nxt    = ST_SHIFT_LO;
            w_cfg_data_nxt = r_shreg[SHR_W-1];
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_LATCH: begin
        // Two divider phases of latch strobe.
        if (w_tick) begin
          if (r_lat_ph) begin
            w_state_nxt     = ST_FINISH;
            w_cfg_latch_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
          end else begin
            w_lat_ph_nxt = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_busy_nxt      = 1'b0;
        w_cfg_clk_nxt   = 1'b0;
        w_cfg_latch_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_word_rem  <= '0;
      r_lat_ph    <= 1'b0;
      r_cfg_clk   <= 1'b0;
      r_cfg_data  <= 1'b0;
      r_cfg_latch <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_word_rem  <= w_word_rem_nxt;
      r_lat_ph    <= w_lat_ph_nxt;
      r_cfg_clk   <= w_cfg_clk_nxt;
      r_cfg_data  <= w_cfg_data_nxt;
      r_cfg_latch <= w_cfg_latch_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_cfg_clk   = r_cfg_clk;
  assign o_cfg_data  = r_cfg_data;
  assign o_cfg_latch = r_cfg_latch;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_cfg_chain_shifter.sv
// Bench for cfg_chain_shifter: random words and gaps against a bit-queue reference model.
module tb_cfg_chain_shifter;

  localparam int unsigned W  = 8;
  localparam int unsigned CL = 12;
  localparam int unsigned CD = 2;
`ifdef CFG_CHAIN_CRC_EN
  localparam int CRC_WORDS = 1;
`else
  localparam int CRC_WORDS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] data = '0;
  logic         ready, cfg_clk, cfg_data, latch, busy, done, err;

  always #5 clk = ~clk;

  cfg_chain_shifter #(.WORD_W(W), .CHAIN_LEN(CL), .CLK_DIV(CD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_word_data  (data),
    .i_word_valid (valid),
    .o_word_ready (ready),
    .o_cfg_clk    (cfg_clk),
    .o_cfg_data   (cfg_data),
    .o_cfg_latch  (latch),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observed chain activity, sampled on the falling clock edge.
  bit   q_bits[$];
  int   hi_run = 0, stable = 0, latch_run = 0;
  int   latch_pulses = 0, last_latch_len = 0, done_cnt = 0, xfers = 0;
  int   bad_phase = 0, bad_setup = 0, bad_hold = 0, bad_done = 0, bad_latch_clk = 0;
  logic p_clk = 1'b0, p_data = 1'b0, p_latch = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hi_run = 0; latch_run = 0; stable = 0;
      p_clk = 1'b0; p_data = 1'b0; p_latch = 1'b0;
    end else begin
      stable = (cfg_data === p_data) ? stable + 1 : 1;
      if (cfg_clk && !p_clk) begin
        q_bits.push_back(cfg_data);
        if (stable < int'(CD) + 1) bad_setup++;
      end
      if (cfg_clk && p_clk && (cfg_data !== p_data)) bad_hold++;
      if (cfg_clk) hi_run++;
      else if (p_clk) begin
        if (hi_run != int'(CD)) bad_phase++;
        hi_run = 0;
      end
      if (latch) begin
        latch_run++;
        if (cfg_clk) bad_latch_clk++;
      end else if (p_latch) begin
        latch_pulses++;
        last_latch_len = latch_run;
        latch_run = 0;
      end
      if (done) begin
        done_cnt++;
        if (!p_latch) bad_done++;
      end
      if (valid && ready) xfers++;
      p_clk = cfg_clk; p_data = cfg_data; p_latch = latch;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] crc_of(input bit bits[$]);
    int c = 0;
    foreach (bits[i]) begin
      int fb = ((c >> 7) & 1) ^ int'(bits[i]);
      c = ((c << 1) & 'hFF) ^ (fb != 0 ? 'h07 : 0);
    end
    return 8'(c);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic offer(input logic [W-1:0] w, input int budget, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    data = w; valid = 1'b1;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    if (!ok) #1;
    valid = 1'b0;
  endtask

  // One configuration pass; expected stream is the words concatenated MSB-first, cut to CL bits.
  task automatic do_pass(input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input int gap, input bit poke, input bit bad_crc);
    bit           exp_bits[$];
    logic [W-1:0] ws[2];
    logic [CL-1:0] act, expv;
    bit           ok, exp_ok;
    int           lp0, dc0, stall_hi;
    logic [7:0]   crcw;
    ws[0] = w0; ws[1] = w1;
    exp_ok = !bad_crc;
    for (int k = 0; k < 2; k++)
      for (int b = int'(W) - 1; b >= 0; b--)
        if (exp_bits.size() < int'(CL)) exp_bits.push_back(ws[k][b]);
    crcw = crc_of(exp_bits);
    if (bad_crc) crcw = crcw ^ 8'h5A;
    q_bits.delete();
    xfers = 0; bad_phase = 0; bad_setup = 0; bad_hold = 0; bad_done = 0; bad_latch_clk = 0;
    lp0 = latch_pulses; dc0 = done_cnt; stall_hi = 0;

    pulse_start();
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'(1));
    check("err_cleared_by_start", 64'(err), 64'(0));
    offer(w0, 400, ok);
    check("xfer_word0", 64'(ok), 64'(1));
    if (poke) pulse_start();
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (i >= gap - 10 && cfg_clk) stall_hi++;
    end
    if (gap >= 50) begin
      check("stall_cfg_clk_low", 64'(stall_hi), 64'(0));
      check("stall_data_held", 64'(cfg_data), 64'(w0[0]));
      check("stall_busy", 64'(busy), 64'(1));
    end
    offer(w1, 400, ok);
    check("xfer_word1", 64'(ok), 64'(1));
    if (CRC_WORDS > 0) begin
      offer(W'(crcw), 400, ok);
      check("xfer_crc_word", 64'(ok), 64'(1));
    end
    offer(W'($urandom), 60, ok);
    check("extra_word_rejected", 64'(ok), 64'(0));
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("pass_ends", 64'(busy), 64'(0));
    check("done_pulses", 64'(done_cnt - dc0), 64'(exp_ok));
    check("latch_pulses", 64'(latch_pulses - lp0), 64'(exp_ok));
    if (exp_ok) check("latch_len", 64'(last_latch_len), 64'(2 * CD));
    check("err_flag", 64'(err), 64'(!exp_ok));
    check("transfers", 64'(xfers), 64'(2 + CRC_WORDS));
    check("bit_count", 64'(q_bits.size()), 64'(CL));
    act = '0; expv = '0;
    for (int i = 0; i < int'(CL); i++) begin
      expv[int'(CL) - 1 - i] = exp_bits[i];
      if (i < q_bits.size()) act[int'(CL) - 1 - i] = q_bits[i];
    end
    check("chain_bits", 64'(act), 64'(expv));
    check("phase_len_errs", 64'(bad_phase), 64'(0));
    check("setup_hold_errs", 64'(bad_setup + bad_hold), 64'(0));
    check("latch_done_order_errs", 64'(bad_done + bad_latch_clk), 64'(0));
  endtask

  initial begin
    bit ok;
    int lp0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({ready, cfg_clk, cfg_data, latch, busy, done, err}), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", 64'({ready, cfg_clk, cfg_data, latch, busy, done, err}), 64'(0));

    do_pass(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    do_pass(W'($urandom), W'($urandom), 50, 1'b0, 1'b0);
    do_pass(W'($urandom), W'($urandom), 2, 1'b1, 1'b0);

    // Reset in the middle of the first word.
    q_bits.delete();
    lp0 = latch_pulses;
    pulse_start();
    offer(W'($urandom), 400, ok);
    check("xfer_before_reset", 64'(ok), 64'(1));
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (q_bits.size() >= 5) break;
    end
    check("bits_before_reset", 64'(q_bits.size() >= 5), 64'(1));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 64'({ready, cfg_clk, cfg_data, latch, busy, done, err}), 64'(0));
    repeat (3) @(negedge clk);
    check("no_latch_after_abort", 64'(latch_pulses - lp0), 64'(0));
    rst_n = 1'b1;
    do_pass(W'($urandom), W'($urandom), int'($urandom_range(0, 6)), 1'b0, 1'b0);

    for (int p = 0; p < 4; p++)
      do_pass(W'($urandom), W'($urandom), int'($urandom_range(0, 6)), 1'b0, 1'b0);

`ifdef CFG_CHAIN_CRC_EN
    do_pass(8'hA5, 8'h3C, 0, 1'b0, 1'b1);
    do_pass(8'hA5, 8'h3C, 0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cfg_chain_shifter.md
Name: cfg_chain_shifter

Overview:
- Transmit end of the fabric configuration chain. Takes configuration words from the loader (valid/ready) and serialises them MSB-first onto the shift-register chain.
- The chain holds the LUT INIT bits, DFF/IOB use flags and BRAM mode bits.
- Generates the chain shift clock, then pulses the chain latch once every chain bit has been shifted.
- Sits between the bitstream loader and the board-level config chain pins.

Parameters:
- WORD_W, 8: width of incoming configuration words.
- CHAIN_LEN, 256: total chain length in bits (≥1; need not be a multiple of WORD_W).
- CLK_DIV, 2: CLK cycles per CFG_CLK phase (≥1); one bit time = 2*CLK_DIV cycles.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  one-cycle request to begin a configuration pass.
- WORD_DATA  input  WORD_W  configuration word, MSB shifted first.
- WORD_VALID  input  1  WORD_DATA valid.
- WORD_READY  output  1  block accepts word this cycle (transfer = VALID & READY).
- CFG_CLK  output  1  chain shift clock; chain samples on rising edge.
- CFG_DATA  output  1  chain serial data.
- CFG_LATCH  output  1  chain parallel-load strobe.
- BUSY  output  1  pass in progress.
- DONE  output  1  one-cycle pulse at end of a successful pass.
- ERR  output  1  sticky error flag; cleared by next START.

Behaviour:
- Reset (async, RST_N=0): state IDLE; CFG_CLK=0, CFG_DATA=0, CFG_LATCH=0, WORD_READY=0, BUSY=0, DONE=0, ERR=0; bit counter and shift register cleared.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, FINISH.
- IDLE:
  - START=1 -> FETCH and BUSY=1 next cycle; ERR cleared.
  - START while BUSY=1 is ignored.
- FETCH:
  - WORD_READY=1 combinationally in this state only.
  - On transfer, load the shift register and set remaining-bits-in-word = min(WORD_W, bits left in chain) -> SHIFT_LO.
  - No transfer -> stay in FETCH (stall); CFG_CLK holds 0 and CFG_DATA holds its last value.
- SHIFT_LO:
  - CFG_CLK=0; CFG_DATA = current MSB, driven on entry.
  - After CLK_DIV cycles -> SHIFT_HI.
- SHIFT_HI:
  - CFG_CLK=1 for CLK_DIV cycles, CFG_DATA stable throughout; then shift register shifts left and chain counter increments.
  - Chain counter == CHAIN_LEN -> LATCH.
  - Else word bits remaining -> SHIFT_LO.
  - Else -> FETCH.
- Partial last word: when CHAIN_LEN mod WORD_W = r ≠ 0, only the upper r bits of the final word are shifted; the lower bits are discarded.
- LATCH: CFG_CLK=0, CFG_LATCH=1 for 2*CLK_DIV cycles -> FINISH.
- FINISH: DONE=1 for one cycle, BUSY=0 -> IDLE.
- CFG_DATA setup/hold relative to the CFG_CLK rise is CLK_DIV cycles each.
- All outputs registered except WORD_READY.
- Counter widths: $clog2(CHAIN_LEN+1) and $clog2(CLK_DIV).
- Extra words offered after the chain is full are not accepted (WORD_READY=0).
- Reset mid-pass aborts immediately; no latch pulse, chain content undefined.

Optional Feature:
- Macro: CFG_CHAIN_CRC_EN.
- Defined:
  - A CRC-8 (poly 0x07, init 0x00) runs over every bit shifted into the chain.
  - After the last chain bit, FETCH accepts one extra word; its low 8 bits are compared with the CRC (WORD_W ≥ 8 required).
  - Match -> LATCH as normal.
  - Mismatch -> no CFG_LATCH, ERR=1, DONE=0, return to IDLE.
- Undefined: no CRC logic and no extra word; ERR stays 0.

Decomposition:
- Package cfg_chain_pkg holds:
  - state enum cfg_state_e;
  - CRC_POLY = 8'h07 and CRC_INIT = 8'h00;
  - function crc8_step(crc, bit).
- One sub-module: cfg_clk_div, a phase-tick counter producing a one-cycle tick every CLK_DIV cycles, restartable from the FSM.

Test Plan (WORD_W=8, CHAIN_LEN=16, CLK_DIV=1 unless noted):
- Basic pass: START, words 0xA5, 0x3C presented back-to-back -> CFG_DATA sampled on CFG_CLK rises = 1010010100111100; CFG_LATCH high 2 cycles; DONE one cycle later; BUSY low afterwards.
- Stall: WORD_VALID withheld 10 cycles before the second word -> CFG_CLK stays 0 for the stall; bit sequence unchanged; only 2 transfers occur.
- Partial word (CHAIN_LEN=12): words 0xFF, 0x9F -> 12 rises, last four bits 1001; third word not accepted.
- Divider (CLK_DIV=3): single word, CHAIN_LEN=8 -> each CFG_CLK phase exactly 3 cycles; CFG_DATA changes only while CFG_CLK=0.
- Async reset asserted during bit 5 -> all outputs 0 immediately; no CFG_LATCH; a new START performs a full pass.
- CFG_CHAIN_CRC_EN: data 0xA5, 0x3C followed by the correct CRC-8 word -> latch and DONE; same data with a wrong CRC word -> ERR=1, no CFG_LATCH, no DONE.
